arm_board_ctrl: RTL and testbench
=================================

ARM_BOARD_CTRL -- requirements
Module: arm_board_ctrl

Interface
REQ-001 SHALL have parameters:
- N_SW, 4: switch channels conditioned (>=2).
- DEB_CYCLES, 500000: consecutive stable cycles for debounce (10 ms at 50 MHz).
- N_DIGITS, 8: seven-segment digits driven.
- RST_IDX, 0: sw_clean bit acting as core reset request.
- MODE_IDX, 1: sw_clean bit selecting step mode.

REQ-002 SHALL have ports:
- CLOCK_50  in  1: single clock, all logic on rising edge.
- rst  in  1: asynchronous, active-low reset.
- sw_in  in  N_SW: raw asynchronous switches.
- key_step  in  1: raw asynchronous pushbutton, active-low (pressed = 0).
- disp_data  in  4*N_DIGITS: core debug word to display.
- sw_clean  out  N_SW: synchronised, debounced switches.
- core_rst  out  1: active-high reset to the ARM core.
- core_en  out  1: core clock enable.
- step_cnt  out  16: count of enabled core cycles.
- hex  out  7*N_DIGITS: active-low segments; digit i = hex[7i+6:7i], bit order g..a.
- mode_led  out  1: 1 in step mode.

Function
REQ-003 SHALL pass each sw_in bit and key_step through its own 2-flop synchroniser.
REQ-004 SHALL debounce each synchronised channel with a counter:
- Counter increments while the synchronised value differs from the clean value.
- Counter clears whenever the two are equal.
- On reaching DEB_CYCLES, the clean value updates and the counter clears.
REQ-005 SHALL reflect a raw level held stable at the clean output exactly DEB_CYCLES+2 cycles after it is first sampled; glitches shorter than DEB_CYCLES SHALL never reach the clean output.
REQ-006 SHALL detect a key press as a debounced key_step 1->0 transition, one cycle wide; release SHALL generate nothing.
REQ-007 SHALL implement a 3-state FSM: HALT, RUN, STEP.
REQ-008 HALT SHALL behave as follows:
- core_rst=1, core_en=0.
- Exit when sw_clean[RST_IDX]=0: to RUN if sw_clean[MODE_IDX]=0, else to STEP.
REQ-009 RUN SHALL drive core_rst=0 and core_en=1 every cycle, and go to STEP when sw_clean[MODE_IDX]=1.
REQ-010 STEP SHALL behave as follows:
- core_rst=0.
- core_en=1 for exactly one cycle, the cycle after each detected press; 0 otherwise.
- Go to RUN when sw_clean[MODE_IDX]=0.
REQ-011 SHALL apply event priority: sw_clean[RST_IDX]=1 in RUN/STEP forces HALT next cycle over all else; a mode change coincident with a press wins, and that press is dropped.
REQ-012 SHALL increment step_cnt on every cycle with core_en=1, wrap 0xFFFF->0x0000, and clear it on entry to HALT.
REQ-013 SHALL latch disp_data into a display register on every cycle with core_en=1; hex SHALL reflect the latched value the following cycle and hold while core_en=0.
REQ-014 SHALL use active-low decode 0..F = 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex); all digits SHALL read 7'h7F (blank) while in HALT.
REQ-015 SHALL make all outputs registered; mode_led SHALL be 1 exactly when the FSM is in STEP.

Reset
REQ-016 SHALL, while rst=0 and independent of clock, drive:
- FSM=HALT, core_rst=1, core_en=0, step_cnt=0, hex all 7'h7F, mode_led=0.
- sw_clean=0, clean key=1, all synchronisers and debounce counters cleared.
REQ-017 SHALL leave HALT on release of rst no earlier than the first rising edge at which sw_clean[RST_IDX]=0 has been evaluated.

Verification (DEB_CYCLES=4, N_DIGITS=8)
REQ-018 Debounce: sw_in[2] high for 3 cycles then low -> sw_clean[2] stays 0; held high -> sw_clean[2]=1 exactly 6 cycles after first sampled.
REQ-019 Run: release rst with sw_in=0 -> HALT->RUN; core_rst 1->0; core_en=1 continuously; step_cnt=1,2,3 on consecutive cycles.
REQ-020 Step: mode switch=1, key_step held low 20 cycles -> exactly one core_en pulse, step_cnt +1; release and press again -> second pulse, +1.
REQ-021 Display: disp_data=32'h0123ABCF latched by core_en -> hex[6:0]=7'h0E, hex[13:7]=7'h46, hex[55:49]=7'h40; in STEP with no press, change disp_data -> hex unchanged.
REQ-022 Wrap/priority: step_cnt=0xFFFF plus one enabled cycle -> 0x0000; reset switch asserted coincident with a press -> HALT, no pulse, step_cnt=0, hex 7'h7F.
REQ-023 Async reset mid-RUN: rst pulled low between edges -> core_en=0, core_rst=1, hex blank before the next rising edge.

Source files
------------

// File: rtl/arm_board_ctrl.sv
// arm_board_ctrl: switch/key conditioning, halt/run/step control
// and seven-segment debug display for an ARM core on a dev board.
module arm_board_ctrl #(
  parameter int N_SW       = 4,
  parameter int DEB_CYCLES = 500000,
  parameter int N_DIGITS   = 8,
  parameter int RST_IDX    = 0,
  parameter int MODE_IDX   = 1
) (
  input  logic                  CLOCK_50,
  input  logic                  rst,
  input  logic [N_SW-1:0]       sw_in,
  input  logic                  key_step,
  input  logic [4*N_DIGITS-1:0] disp_data,
  output logic [N_SW-1:0]       sw_clean,
  output logic                  core_rst,
  output logic                  core_en,
  output logic [15:0]           step_cnt,
  output logic [7*N_DIGITS-1:0] hex,
  output logic                  mode_led
);

  localparam int NCH = N_SW + 1;
  localparam int CW  = $clog2(DEB_CYCLES + 1);
  localparam logic [NCH-1:0] CH_RST =
    {1'b1, {N_SW{1'b0}}};
  localparam logic [CW-1:0] DEB_MAX = CW'(DEB_CYCLES);
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [7*N_DIGITS-1:0] BLANK =
    {N_DIGITS{7'h7F}};

  typedef enum logic [1:0] {
    HALT,
    RUN,
    STEP
  } state_t;

  logic [NCH-1:0]        w_raw;
  logic [NCH-1:0]        r_s1;
  logic [NCH-1:0]        r_s2;
  logic [NCH-1:0]        r_clean;
  logic [CW-1:0]         r_cnt [NCH];
  logic                  r_key_d;
  logic                  w_press;
  logic                  w_rst_sw;
  logic                  w_mode_sw;
  state_t                r_state;
  state_t                w_next;
  logic                  w_en_next;
  logic [4*N_DIGITS-1:0] r_disp;
  logic [4*N_DIGITS-1:0] w_disp;
  logic [7*N_DIGITS-1:0] w_hex;

  // key rides along as the top channel; it idles high
  assign w_raw     = {key_step, sw_in};
  assign sw_clean  = r_clean[N_SW-1:0];
  assign w_press   = r_key_d & ~r_clean[N_SW];
  assign w_rst_sw  = r_clean[RST_IDX];
  assign w_mode_sw = r_clean[MODE_IDX];

  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      r_s1    <= CH_RST;
      r_s2    <= CH_RST;
      r_clean <= CH_RST;
      r_key_d <= 1'b1;
      for (int i = 0; i < NCH; i++)
        r_cnt[i] <= '0;
    end else begin
      r_s1    <= w_raw;
      r_s2    <= r_s1;
      r_key_d <= r_clean[N_SW];
      for (int i = 0; i < NCH; i++) begin
        if (r_s2[i] == r_clean[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DEB_MAX) begin
          r_clean[i] <= r_s2[i];
          r_cnt[i]   <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + ONE;
        end
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    w_en_next = 1'b0;
    unique case (r_state)
      HALT: begin
        if (!w_rst_sw)
          w_next = w_mode_sw ? STEP : RUN;
      end
      RUN: begin
        if (w_rst_sw)
          w_next = HALT;
        else if (w_mode_sw)
          w_next = STEP;
      end
      STEP: begin
        if (w_rst_sw)
          w_next = HALT;
        else if (!w_mode_sw)
          w_next = RUN;
        else
          w_en_next = w_press;
      end
      default: w_next = HALT;
    endcase
    if (w_next == RUN)
      w_en_next = 1'b1;
  end

  function automatic logic [6:0] seg7(
    input logic [3:0] v
  );
    logic [6:0] s;
    s = 7'h7F;
    unique case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // decode from the live word on an enabled cycle so hex follows next cycle
  assign w_disp = core_en ? disp_data : r_disp;

  always_comb begin
    w_hex = BLANK;
    for (int d = 0; d < N_DIGITS; d++)
      w_hex[7*d +: 7] = seg7(w_disp[4*d +: 4]);
  end

  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      r_state  <= HALT;
      core_rst <= 1'b1;
      core_en  <= 1'b0;
      mode_led <= 1'b0;
      step_cnt <= '0;
      hex      <= BLANK;
      r_disp   <= '0;
    end else begin
      r_state  <= w_next;
      core_rst <= (w_next == HALT);
      core_en  <= w_en_next;
      mode_led <= (w_next == STEP);
      r_disp   <= w_disp;
      if (w_next == HALT)
        step_cnt <= '0;
      else if (core_en)
        step_cnt <= step_cnt + 16'd1;
      hex <= (w_next == HALT) ? BLANK : w_hex;
    end
  end

endmodule

// File: tb/tb_arm_board_ctrl.sv
// Scoreboard bench for arm_board_ctrl: a reference model predicts every
// output per cycle; a monitor compares on each falling edge.
module tb_arm_board_ctrl;

  localparam int N_SW = 4;
  localparam int DEB  = 4;
  localparam int ND   = 8;
  localparam int RIDX = 0;
  localparam int MIDX = 1;
  localparam int NCH  = N_SW + 1;
  localparam logic [7*ND-1:0] BLANK = {ND{7'h7F}};
  localparam logic [6:0] SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic            clk = 1'b0;
  logic            rst;
  logic [N_SW-1:0] sw_in;
  logic            key_step;
  logic [4*ND-1:0] disp_data;
  logic [N_SW-1:0] sw_clean;
  logic            core_rst;
  logic            core_en;
  logic [15:0]     step_cnt;
  logic [7*ND-1:0] hex;
  logic            mode_led;

  arm_board_ctrl #(
    .N_SW(N_SW), .DEB_CYCLES(DEB), .N_DIGITS(ND),
    .RST_IDX(RIDX), .MODE_IDX(MIDX)
  ) dut (
    .CLOCK_50(clk), .rst(rst), .sw_in(sw_in),
    .key_step(key_step), .disp_data(disp_data),
    .sw_clean(sw_clean), .core_rst(core_rst),
    .core_en(core_en), .step_cnt(step_cnt),
    .hex(hex), .mode_led(mode_led)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_pulse = 0;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40)
        $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7*ND-1:0] dec(input logic [4*ND-1:0] d);
    logic [7*ND-1:0] r;
    for (int i = 0; i < ND; i++)
      r[7*i +: 7] = SEG[d[4*i +: 4]];
    return r;
  endfunction

  // ---------------- reference model ----------------
  typedef enum int {M_HALT, M_RUN, M_STEP} mmode_t;
  typedef struct {
    logic [N_SW-1:0] sw;
    logic            crst;
    logic            en;
    logic [15:0]     cnt;
    logic [7*ND-1:0] hx;
    logic            led;
  } snap_t;

  snap_t           exp_q[$];
  logic [NCH-1:0]  hist[$];
  logic [NCH-1:0]  m_clean;
  logic            m_key_prev;
  mmode_t          m_mode;
  logic            m_en;
  logic [15:0]     m_cnt;
  logic [4*ND-1:0] m_disp;

  task automatic model_reset();
    hist.delete();
    exp_q.delete();
    for (int i = 0; i < DEB + 3; i++)
      hist.push_back({1'b1, {N_SW{1'b0}}});
    m_clean    = {1'b1, {N_SW{1'b0}}};
    m_key_prev = 1'b1;
    m_mode     = M_HALT;
    m_en       = 1'b0;
    m_cnt      = '0;
    m_disp     = '0;
  endtask

  task automatic model_step();
    logic [NCH-1:0]  nc;
    logic            press;
    logic            en_n;
    logic            flip;
    mmode_t          nm;
    logic [4*ND-1:0] shown;
    snap_t           s;
    hist.push_back({key_step, sw_in});
    // a level becomes clean once the DEB+1 samples that reached
    // the debouncer (two edges late) all disagree with the old value
    nc = m_clean;
    for (int b = 0; b < NCH; b++) begin
      flip = 1'b1;
      for (int j = 2; j <= DEB + 2; j++)
        if (hist[hist.size() - 1 - j][b] == m_clean[b])
          flip = 1'b0;
      if (flip) nc[b] = ~m_clean[b];
    end
    while (hist.size() > DEB + 4) void'(hist.pop_front());
    press = m_key_prev & ~m_clean[N_SW];
    if (m_clean[RIDX])      nm = M_HALT;
    else if (m_clean[MIDX]) nm = M_STEP;
    else                    nm = M_RUN;
    en_n = (nm == M_RUN) ||
           (m_mode == M_STEP && nm == M_STEP && press);
    if (nm == M_HALT) m_cnt = '0;
    else if (m_en)    m_cnt = m_cnt + 16'd1;
    shown  = m_en ? disp_data : m_disp;
    m_disp = shown;
    m_key_prev = m_clean[N_SW];
    m_clean    = nc;
    m_mode     = nm;
    m_en       = en_n;
    s.sw   = m_clean[N_SW-1:0];
    s.crst = (nm == M_HALT);
    s.en   = en_n;
    s.cnt  = m_cnt;
    s.hx   = (nm == M_HALT) ? BLANK : dec(shown);
    s.led  = (nm == M_STEP);
    exp_q.push_back(s);
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else      model_step();
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    snap_t e;
    if (rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_sw_clean", sw_clean, e.sw);
      check("sb_core_rst", core_rst, e.crst);
      check("sb_core_en",  core_en,  e.en);
      check("sb_step_cnt", step_cnt, e.cnt);
      check("sb_hex",      hex,      e.hx);
      check("sb_mode_led", mode_led, e.led);
    end
  end

  always @(negedge clk)
    if (rst && core_en) n_pulse++;

  // ---------------- stimulus ----------------
  initial begin
    int p0;
    int idx;
    bit found;
    rst = 1'b0; sw_in = '0; key_step = 1'b1; disp_data = '0;
    #12;
    check("rst_sw_clean", sw_clean, 0);
    check("rst_core_rst", core_rst, 1);
    check("rst_core_en",  core_en,  0);
    check("rst_step_cnt", step_cnt, 0);
    check("rst_hex",      hex,      BLANK);
    check("rst_mode_led", mode_led, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // straight into RUN
    @(posedge clk); #1;
    check("run_core_rst", core_rst, 0);
    check("run_core_en",  core_en,  1);
    check("run_cnt0",     step_cnt, 0);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      check("run_cnt", step_cnt, i);
      check("run_en_held", core_en, 1);
    end

    // debounce: short glitch then a held level
    @(negedge clk); sw_in[2] = 1'b1;
    repeat (3) @(negedge clk); sw_in[2] = 1'b0;
    repeat (12) @(negedge clk);
    check("deb_glitch", sw_clean[2], 0);
    sw_in[2] = 1'b1;
    repeat (6) @(posedge clk); #1;
    check("deb_early", sw_clean[2], 0);
    @(posedge clk); #1;
    check("deb_on", sw_clean[2], 1);

    // reset switch -> HALT
    @(negedge clk); sw_in[RIDX] = 1'b1;
    repeat (12) @(negedge clk);
    check("halt_core_rst", core_rst, 1);
    check("halt_core_en",  core_en,  0);
    check("halt_cnt",      step_cnt, 0);
    check("halt_hex",      hex,      BLANK);
    check("halt_led",      mode_led, 0);

    // step mode: one pulse per press
    disp_data = 32'h0123ABCF;
    sw_in[RIDX] = 1'b0; sw_in[MIDX] = 1'b1;
    repeat (12) @(negedge clk);
    check("step_led", mode_led, 1);
    check("step_idle_cnt", step_cnt, 0);
    p0 = n_pulse;
    key_step = 1'b0; repeat (20) @(negedge clk);
    key_step = 1'b1; repeat (20) @(negedge clk);
    check("step_pulse1", n_pulse - p0, 1);
    check("step_cnt1", step_cnt, 1);
    check("hex_d0", hex[6:0], 7'h0E);
    check("hex_d1", hex[13:7], 7'h46);
    check("hex_d7", hex[55:49], 7'h40);
    disp_data = 32'hFFFF0000;
    repeat (5) @(negedge clk);
    check("hex_hold", hex, dec(32'h0123ABCF));
    key_step = 1'b0; repeat (20) @(negedge clk);
    key_step = 1'b1; repeat (20) @(negedge clk);
    check("step_pulse2", n_pulse - p0, 2);
    check("step_cnt2", step_cnt, 2);
    check("hex2_d0", hex[6:0], 7'h40);
    check("hex2_d7", hex[55:49], 7'h0E);

    // reset switch coincident with a press
    p0 = n_pulse;
    sw_in[RIDX] = 1'b1; key_step = 1'b0;
    repeat (20) @(negedge clk);
    check("prio_no_pulse", n_pulse - p0, 0);
    check("prio_core_rst", core_rst, 1);
    check("prio_cnt", step_cnt, 0);
    check("prio_hex", hex, BLANK);
    key_step = 1'b1; sw_in = '0;
    repeat (12) @(negedge clk);

    // random traffic, scoreboard does the checking
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) begin
        idx = $urandom_range(1, N_SW - 1);
        sw_in[idx] = ~sw_in[idx];
      end
      if ($urandom_range(0, 39) == 0) sw_in[RIDX] = ~sw_in[RIDX];
      if ($urandom_range(0, 4) == 0)  key_step = ~key_step;
      disp_data = $urandom;
    end

    // counter wrap in RUN
    @(negedge clk); sw_in = '0; key_step = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 70000 && !found; i++) begin
      @(negedge clk);
      if (step_cnt == 16'hFFFF) found = 1'b1;
    end
    check("wrap_reached", found, 1);
    @(negedge clk);
    check("wrap_zero", step_cnt, 0);

    // async reset between edges
    repeat (3) @(negedge clk);
    check("pre_arst_en", core_en, 1);
    @(posedge clk); #3; rst = 1'b0; #1;
    check("arst_core_en",  core_en,  0);
    check("arst_core_rst", core_rst, 1);
    check("arst_hex",      hex,      BLANK);
    check("arst_cnt",      step_cnt, 0);
    check("arst_led",      mode_led, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
